// File: rtl/accum_job_sched.sv
// Job scheduler that shares one accumulate unit among N requesters.
// Arbitrates round-robin per job and gathers the B vector from lane beats.
// It issues a one-cycle din_en and returns tagged results through a
// credit-guarded FIFO.
// Ports:
//   clk, rst (sync, active-low)
//   req/gnt                  request and one-hot grant per requester
//   beat_* / beat_rdy        beat bus from the granted requester
//   acc_a/acc_b/acc_din_en   issue to the unit
//   acc_res_en/acc_res       result from the unit
//   rsp_*                    tagged response stream
//   err                      sticky flag for a result with no job in flight
module accum_job_sched #(
    parameter  int N     = 4,
    parameter  int LANES = 4,
    parameter  int RQ    = 8,
    parameter  int DRAIN = 10,
    localparam int W     = 68,
    localparam int NB    = 108,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    output logic [N-1:0]       gnt,
    input  logic               beat_vld,
    output logic               beat_rdy,
    input  logic [LANES*W-1:0] beat_b,
    input  logic [W-1:0]       beat_a,
    input  logic               beat_last,
    output logic [W-1:0]       acc_a,
    output logic [NB*W-1:0]    acc_b,
    output logic               acc_din_en,
    input  logic               acc_res_en,
    input  logic [W-1:0]       acc_res,
    output logic               rsp_vld,
    input  logic               rsp_rdy,
    output logic [IW-1:0]      rsp_id,
    output logic [W-1:0]       rsp_data,
    output logic               err
);

    localparam int BEATS = NB / LANES;
    localparam int CBW   = $clog2(BEATS + 1);
    localparam int PW    = $clog2(RQ);
    localparam int CW    = $clog2(RQ) + 1;
    localparam int DW    = $clog2(DRAIN + 1);

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        ISSUE
    } state_t;

    state_t state_q, state_d;

    logic [CBW-1:0]  cnt_q;
    logic [IW-1:0]   rr_q, gid_q;
    logic [N-1:0]    gnt_q;
    logic [W-1:0]    a_q;
    logic [NB*W-1:0] b_q;

    logic [IW-1:0]   tag_mem [RQ];
    logic [PW-1:0]   tag_wr, tag_rd;
    logic [IW+W-1:0] rsp_mem [RQ];
    logic [PW-1:0]   f_wr, f_rd;
    logic [CW-1:0]   f_cnt, outst;
    logic [CW:0]     credit_sum;

    logic [DW-1:0]   drain_q;
    logic            err_q, retire_q;

    logic            accept, job_end, issue, pop;
    logic            res_live, have_job, retire_d, spurious;
    logic            pick_vld;
    logic [IW-1:0]   pick_id;
    int              pick_k;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(RQ - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept     = beat_vld & beat_rdy;
    assign job_end    = accept &
                        (beat_last | (cnt_q == CBW'(BEATS - 1)));
    assign credit_sum = {1'b0, outst} + {1'b0, f_cnt};
    assign pop        = rsp_vld & rsp_rdy;

    // A retire already latched in retire_q still counts in outst,
    // so it is subtracted before deciding whether a tag is left.
    assign res_live = (drain_q == '0);
    assign have_job = outst > CW'(retire_q);
    assign retire_d = acc_res_en & res_live & have_job;
    assign spurious = acc_res_en & res_live & ~have_job;

    // First requester at or after the rr pointer; the loop runs
    // downward so the smallest offset is the last to assign.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        pick_k   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            pick_k = (int'(rr_q) + i) % N;
            if (req[pick_k]) begin
                pick_vld = 1'b1;
                pick_id  = IW'(pick_k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_vld) state_d = GATHER;
            GATHER:  if (job_end)  state_d = ISSUE;
            ISSUE:   if (issue)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_rdy = (state_q == GATHER);
        issue    = (state_q == ISSUE) &&
                   (credit_sum < (CW + 1)'(RQ));
        acc_din_en = issue;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_q     <= '0;
            gid_q    <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            f_wr     <= '0;
            f_rd     <= '0;
            f_cnt    <= '0;
            outst    <= '0;
            drain_q  <= DW'(DRAIN);
            err_q    <= 1'b0;
            retire_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                cnt_q <= '0;
                if (pick_vld) begin
                    gnt_q <= N'(1) << pick_id;
                    gid_q <= pick_id;
                end
            end
            if (accept) cnt_q <= cnt_q + 1'b1;
            if (issue) begin
                gnt_q  <= '0;
                rr_q   <= (gid_q == IW'(N - 1)) ? '0 : gid_q + 1'b1;
                tag_wr <= inc(tag_wr);
            end
            if (retire_q) begin
                tag_rd <= inc(tag_rd);
                f_wr   <= inc(f_wr);
            end
            if (pop) f_rd <= inc(f_rd);
            outst <= outst + CW'(issue) - CW'(retire_q);
            f_cnt <= f_cnt + CW'(retire_q) - CW'(pop);
            if (drain_q != '0) drain_q <= drain_q - 1'b1;
            if (spurious) err_q <= 1'b1;
            retire_q <= retire_d;
        end
    end

    // Operand staging; slots beyond the last written beat are
    // zeroed on the beat that ends the job.
    always_ff @(posedge clk) begin
        if (accept && cnt_q == '0) a_q <= beat_a;
        for (int j = 0; j < BEATS; j++) begin
            for (int l = 0; l < LANES; l++) begin
                if (accept && cnt_q == CBW'(j))
                    b_q[(j*LANES+l)*W +: W] <= beat_b[l*W +: W];
                else if (job_end && CBW'(j) > cnt_q)
                    b_q[(j*LANES+l)*W +: W] <= '0;
            end
        end
    end

    // acc_res is valid the cycle after acc_res_en, hence the push
    // is driven from the registered retire flag.
    always_ff @(posedge clk) begin
        if (issue) tag_mem[tag_wr] <= gid_q;
        if (retire_q) rsp_mem[f_wr] <= {tag_mem[tag_rd], acc_res};
    end

    assign gnt                = gnt_q;
    assign acc_a              = a_q;
    assign acc_b              = b_q;
    assign rsp_vld            = (f_cnt != '0);
    assign {rsp_id, rsp_data} = rsp_mem[f_rd];
    assign err                = err_q;

endmodule
